sram_sp_param: RTL



---
 rtl/sram_sp_param.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sram_sp_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sram_sp_param : parametrised single-port SRAM with a clear sequencer,
//                 registered reads, busy flag and out-of-range detection.
//                 Optional macro SRAM_OUT_REG_EN adds a second output stage.
// Revision      : 1.0
// ============================================================================
module sram_sp_param #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic              clr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              err
);

  localparam logic [0:0]      ST_CLEAR = 1'b0;
  localparam logic [0:0]      ST_READY = 1'b1;
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C   = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q,   state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              busy_q,    busy_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              rvalid_q,  rvalid_d;
  logic              rerr_q,    rerr_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic              in_range;

  // Widened unsigned compare so DEPTH == 2**ADDR_W is handled.
  assign in_range = ({1'b0, address} < DEPTH_C);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    rerr_d    = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = address[IDX_W-1:0];
    mem_wdata = in_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = clr_cnt_q[IDX_W-1:0];
        mem_wdata = INIT_VAL;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_C) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      default: begin
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          busy_d    = 1'b1;
        end else if (en) begin
          if (!in_range) begin
            rerr_d = 1'b1;
          end else if (we) begin
            mem_we  = 1'b1;
            rdata_d = in_data;
          end else begin
            rdata_d  = mem[mem_idx];
            rvalid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      rerr_q    <= rerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  assign busy = busy_q;

`ifdef SRAM_OUT_REG_EN
  logic [DATA_W-1:0] data2_q,  data2_d;
  logic              valid2_q, valid2_d;
  logic              err2_q,   err2_d;

  // An accepted clr flushes whatever is still in flight in the second stage.
  always_comb begin
    data2_d  = rdata_q;
    valid2_d = rvalid_q;
    err2_d   = rerr_q;
    if ((state_q == ST_READY) && clr) begin
      valid2_d = 1'b0;
      err2_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data2_q  <= '0;
      valid2_q <= 1'b0;
      err2_q   <= 1'b0;
    end else begin
      data2_q  <= data2_d;
      valid2_q <= valid2_d;
      err2_q   <= err2_d;
    end
  end

  assign out_data  = data2_q;
  assign out_valid = valid2_q;
  assign err       = err2_q;
`else
  assign out_data  = rdata_q;
  assign out_valid = rvalid_q;
  assign err       = rerr_q;
`endif

endmodule
`default_nettype wire
